if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and issues single-outstanding fetches to a variable-latency instruction memory.
- Drives the IF/ID pipeline register (id_instr, id_pc4) consumed by decode, control and hazard detection.
- Honours the load-use stall from hazard detection, the branch redirect from MEM and the jump redirect from ID.

---
 rtl/if_stage.sv | 166 ++++++++++++++++
 tb/tb_if_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, issues one outstanding fetch at a time to a variable-latency
// instruction memory and drives the IF/ID register consumed by decode.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   stall                   load-use stall; freezes PC and IF/ID
//   br_taken, br_target     MEM-stage branch redirect (highest priority)
//   jmp_taken, jmp_target   ID-stage jump redirect
//   imem_req, imem_addr     fetch request and word-aligned byte address
//   imem_ack, imem_rdata    response strobe and instruction word
//   id_instr, id_pc4        IF/ID instruction and PC+4
//   id_valid                IF/ID holds a real instruction
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_taken,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] pc, pc_nx, pc_plus4;
    logic            kill, kill_nx;
    logic [XLEN-1:0] hold_instr, hold_instr_nx;
    logic [XLEN-1:0] hold_pc4, hold_pc4_nx;
    logic            imem_req_nx;
    logic [XLEN-1:0] imem_addr_nx;
    logic [XLEN-1:0] id_instr_nx, id_pc4_nx;
    logic            id_valid_nx;
    logic            redirect;
    logic            fetch_active;
    logic            load_id;
    logic [XLEN-1:0] target;

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc4   <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            id_instr   <= NOP_INSTR;
            id_pc4     <= '0;
            id_valid   <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            kill       <= kill_nx;
            hold_instr <= hold_instr_nx;
            hold_pc4   <= hold_pc4_nx;
            imem_req   <= imem_req_nx;
            imem_addr  <= imem_addr_nx;
            id_instr   <= id_instr_nx;
            id_pc4     <= id_pc4_nx;
            id_valid   <= id_valid_nx;
        end
    end

    // Next-state, PC, hold buffer and IF/ID update
    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        kill_nx       = kill;
        hold_instr_nx = hold_instr;
        hold_pc4_nx   = hold_pc4;
        id_instr_nx   = id_instr;
        id_pc4_nx     = id_pc4;
        id_valid_nx   = id_valid;
        load_id       = 1'b0;

        pc_plus4 = pc + PC_STEP;
        redirect = br_taken | jmp_taken;
        target   = (br_taken ? br_target : jmp_target) & ALIGN_MASK;
        // REQ right after reset has imem_req low: nothing is in flight yet
        fetch_active = (state == S_WAIT) || ((state == S_REQ) && imem_req);

        if (redirect) begin
            pc_nx       = target;
            id_instr_nx = NOP_INSTR;
            id_valid_nx = 1'b0;
            if (fetch_active && !imem_ack) begin
                // Response still owed for the old address: wait it out, drop it
                kill_nx  = 1'b1;
                state_nx = S_WAIT;
            end else begin
                kill_nx  = 1'b0;
                state_nx = S_REQ;
            end
        end else begin
            case (state)
                S_REQ, S_WAIT: begin
                    if (fetch_active) begin
                        if (imem_ack) begin
                            state_nx = S_REQ;
                            if (kill) begin
                                kill_nx = 1'b0;
                            end else if (!stall) begin
                                id_instr_nx = imem_rdata;
                                id_pc4_nx   = pc_plus4;
                                id_valid_nx = 1'b1;
                                pc_nx       = pc_plus4;
                                load_id     = 1'b1;
                            end else begin
                                hold_instr_nx = imem_rdata;
                                hold_pc4_nx   = pc_plus4;
                                pc_nx         = pc_plus4;
                                state_nx      = S_HOLD;
                            end
                        end else begin
                            state_nx = S_WAIT;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        id_instr_nx = hold_instr;
                        id_pc4_nx   = hold_pc4;
                        id_valid_nx = 1'b1;
                        load_id     = 1'b1;
                        state_nx    = S_REQ;
                    end
                end
                default: begin
                    state_nx = S_REQ;
                end
            endcase

            // No word delivered and decode is free to advance: insert a bubble
            if (!stall && !load_id) begin
                id_instr_nx = NOP_INSTR;
                id_valid_nx = 1'b0;
            end
        end

        // Address only moves when a fresh request is about to be presented
        imem_req_nx  = (state_nx != S_HOLD);
        imem_addr_nx = (state_nx == S_REQ) ? pc_nx : imem_addr;
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage. Memory returns addr ^ MEM_KEY;
// ack is driven directly, tied to imem_req, or delayed to a 3-cycle latency.
module tb_if_stage;

    localparam logic [31:0] MEM_KEY = 32'hA5A5_5A5A;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_taken;
    logic [31:0] jmp_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;

    logic [1:0]  ack_mode;   // 0 = direct, 1 = tied to req, 2 = 3-cycle latency
    logic        ack_drv;
    logic [1:0]  wcnt;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_taken  (jmp_taken),
        .jmp_target (jmp_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_instr   (id_instr),
        .id_pc4     (id_pc4),
        .id_valid   (id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ MEM_KEY;
    endfunction

    assign imem_rdata = mem(imem_addr);
    assign imem_ack   = (ack_mode == 2'd0) ? ack_drv :
                        (ack_mode == 2'd1) ? imem_req :
                        (imem_req && (wcnt == 2'd2));

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 2'd0;
        else                       wcnt <= wcnt + 2'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_id(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] p4);
        check({tag, ".valid"}, 32'(id_valid), 32'(v));
        check({tag, ".instr"}, id_instr, ins);
        if (v) check({tag, ".pc4"}, id_pc4, p4);
    endtask

    task automatic check_fetch(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".req"}, 32'(imem_req), 32'(req));
        if (req) check({tag, ".addr"}, imem_addr, addr);
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        stall      = 1'b0;
        br_taken   = 1'b0;
        jmp_taken  = 1'b0;
        br_target  = '0;
        jmp_target = '0;
        ack_drv    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // E1: request for 0 presented; E2: word 0 delivered to IF/ID, addr 4 requested
    task automatic prime_first_word();
        tick();
        ack_drv = 1'b1;
        tick();
        check_id("prime", 1'b1, mem(32'h0), 32'h4);
    endtask

    initial begin
        ack_mode = 2'd0;
        do_reset();
        tick();
        reset = 1'b1;
        tick();
        check_id("rst", 1'b0, NOP, 32'h0);
        check("rst.pc4", id_pc4, 32'h0);
        check("rst.req", 32'(imem_req), 32'h0);
        check("rst.addr", imem_addr, 32'h0);

        // Zero-wait memory: one instruction per cycle
        ack_mode = 2'd1;
        do_reset();
        tick();
        check_fetch("zw.e1", 1'b1, 32'h0);
        check("zw.e1.valid", 32'(id_valid), 32'h0);
        for (int k = 2; k <= 6; k++) begin
            tick();
            check_id($sformatf("zw.e%0d", k), 1'b1, mem(32'(4 * (k - 2))), 32'(4 * (k - 1)));
            check_fetch($sformatf("zw.e%0d", k), 1'b1, 32'(4 * (k - 1)));
        end

        // 3-cycle latency: address held 3 cycles, one valid pulse per 3 cycles
        ack_mode = 2'd2;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            logic        ev;
            int unsigned slot;
            tick();
            slot = 32'((c - 1) / 3);
            ev   = (c >= 4) && (c % 3 == 1);
            check_fetch($sformatf("lat.e%0d", c), 1'b1, 32'(4 * slot));
            check_id($sformatf("lat.e%0d", c), ev, ev ? mem(32'(4 * (slot - 1))) : NOP,
                     32'(4 * slot));
        end

        // Ack during a stall parks the word in HOLD until the stall drops
        ack_mode = 2'd0;
        do_reset();
        prime_first_word();
        stall   = 1'b1;
        ack_drv = 1'b0;
        tick();
        check_id("st.e3", 1'b1, mem(32'h0), 32'h4);
        check_fetch("st.e3", 1'b1, 32'h4);
        ack_drv = 1'b1;
        tick();
        check_id("st.e4", 1'b1, mem(32'h0), 32'h4);
        check("st.e4.req", 32'(imem_req), 32'h0);
        ack_drv = 1'b0;
        tick();
        check_id("st.e5", 1'b1, mem(32'h0), 32'h4);
        check("st.e5.req", 32'(imem_req), 32'h0);
        stall = 1'b0;
        tick();
        check_id("st.e6", 1'b1, mem(32'h4), 32'h8);
        check_fetch("st.e6", 1'b1, 32'h8);
        ack_drv = 1'b1;
        tick();
        check_id("st.e7", 1'b1, mem(32'h8), 32'hC);

        // Jump while a fetch is outstanding: stale word discarded, target fetched
        do_reset();
        prime_first_word();
        stall   = 1'b1;
        ack_drv = 1'b0;
        tick();
        jmp_taken  = 1'b1;
        jmp_target = 32'h43;
        tick();
        check_id("jmp.e4", 1'b0, NOP, 32'h0);
        check_fetch("jmp.e4", 1'b1, 32'h4);
        jmp_taken = 1'b0;
        stall     = 1'b0;
        ack_drv   = 1'b1;
        tick();
        check_id("jmp.e5", 1'b0, NOP, 32'h0);
        check_fetch("jmp.e5", 1'b1, 32'h40);
        tick();
        check_id("jmp.e6", 1'b1, mem(32'h40), 32'h44);

        // Branch beats jump in the same cycle, even under stall and with an ack
        do_reset();
        prime_first_word();
        stall      = 1'b1;
        br_taken   = 1'b1;
        br_target  = 32'h100;
        jmp_taken  = 1'b1;
        jmp_target = 32'h200;
        tick();
        check_id("br.e3", 1'b0, NOP, 32'h0);
        check_fetch("br.e3", 1'b1, 32'h100);
        br_taken  = 1'b0;
        jmp_taken = 1'b0;
        stall     = 1'b0;
        tick();
        check_id("br.e4", 1'b1, mem(32'h100), 32'h104);

        // PC wrap at the top of the address space
        do_reset();
        jmp_taken  = 1'b1;
        jmp_target = 32'hFFFF_FFFC;
        tick();
        check_fetch("wrap.e1", 1'b1, 32'hFFFF_FFFC);
        jmp_taken = 1'b0;
        ack_drv   = 1'b1;
        tick();
        check_id("wrap.e2", 1'b1, mem(32'hFFFF_FFFC), 32'h0);
        check_fetch("wrap.e2", 1'b1, 32'h0);

        // Reset in WAIT, then a late ack while req is still low must be ignored
        ack_drv = 1'b0;
        tick();
        check_fetch("rw.e3", 1'b1, 32'h0);
        reset = 1'b1;
        tick();
        check_id("rw.e4", 1'b0, NOP, 32'h0);
        check("rw.e4.pc4", id_pc4, 32'h0);
        check("rw.e4.req", 32'(imem_req), 32'h0);
        check("rw.e4.addr", imem_addr, 32'h0);
        reset   = 1'b0;
        ack_drv = 1'b1;
        tick();
        check_id("rw.e5", 1'b0, NOP, 32'h0);
        check_fetch("rw.e5", 1'b1, 32'h0);
        tick();
        check_id("rw.e6", 1'b1, mem(32'h0), 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
